// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first, idle-high) fed by a valid/ready byte FIFO.
// The stop-bit exit pops straight into the next start bit, so queued frames go out back-to-back.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      shifter, shifter_n;
    logic [2:0]      bitidx, bitidx_n;
    logic [BW-1:0]   baud, baud_n;
    logic            tx_n;
    logic            push, pop, empty, full, baud_last;

    assign full      = (fifo_count == CW'(FIFO_DEPTH));
    assign empty     = (fifo_count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && in_ready;
    assign busy      = (state != S_IDLE);
    assign baud_last = (baud == BAUD_LAST);

    always_comb begin
        state_n   = state;
        tx_n      = tx;
        shifter_n = shifter;
        bitidx_n  = bitidx;
        baud_n    = baud;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shifter_n = mem[rd_ptr];
                    tx_n      = 1'b0;
                    baud_n    = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_n   = '0;
                    tx_n     = shifter[0];
                    bitidx_n = '0;
                    state_n  = S_DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bitidx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = S_STOP;
                    end else begin
                        shifter_n = shifter >> 1;
                        tx_n      = shifter[1];
                        bitidx_n  = bitidx + 1'b1;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (!empty) begin
                        pop       = 1'b1;
                        shifter_n = mem[rd_ptr];
                        tx_n      = 1'b0;
                        state_n   = S_START;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            shifter    <= '0;
            bitidx     <= '0;
            baud       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            shifter <= shifter_n;
            bitidx  <= bitidx_n;
            baud    <= baud_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage is not reset; clearing the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a UART line monitor decodes frames and
// compares them against a scoreboard of accepted bytes.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ  (12000000),
        .BAUD      (1000000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx        (tx),
        .busy      (busy),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int frames_rx = 0;
    int frames_started = 0;
    int mon_epoch = 0;
    logic [9:0] last_bits = '0;
    logic [7:0] exp_q[$];
    int start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One negedge: present inputs for the coming edge and record the byte if it will be taken.
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        if (v && in_ready) exp_q.push_back(d);
    endtask

    task automatic wait_frames(input string tag, input int target, input int limit);
        for (int i = 0; i < limit && frames_rx < target; i++) @(negedge clk);
        check(tag, frames_rx, target);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        for (int i = 0; i < limit && busy; i++) @(negedge clk);
        check(tag, busy, 1'b0);
    endtask

    // Line monitor: samples each bit at its middle (cycle 6 of 12).
    initial begin
        int         mon_cyc;
        int         my_epoch;
        logic       active;
        logic [9:0] bits;
        logic [7:0] exp_b;
        mon_cyc  = 0;
        my_epoch = 0;
        active   = 1'b0;
        bits     = '0;
        forever begin
            @(negedge clk);
            if (rst || my_epoch != mon_epoch) begin
                active   = 1'b0;
                my_epoch = mon_epoch;
            end else if (!active) begin
                if (tx == 1'b0) begin
                    active  = 1'b1;
                    mon_cyc = 1;
                    frames_started++;
                    start_q.push_back(cyc);
                end
            end else begin
                mon_cyc++;
                if (mon_cyc >= 6 && (mon_cyc - 6) % 12 == 0) begin
                    bits[(mon_cyc - 6) / 12] = tx;
                    if (mon_cyc == 114) begin
                        active    = 1'b0;
                        last_bits = bits;
                        frames_rx++;
                        check("rx_start", bits[0], 1'b0);
                        check("rx_stop", bits[9], 1'b1);
                        check("sb_nonempty", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", bits[8:1], exp_b);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int busy_cnt;
        int peak;
        int tx_low;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", fifo_count, 3'd0);
        check("rst_ready", in_ready, 1'b1);
        rst = 1'b0;

        // 1: idle line after reset
        repeat (50) begin
            @(negedge clk);
            check("t1_tx", tx, 1'b1);
            check("t1_busy", busy, 1'b0);
            check("t1_cnt", fifo_count, 3'd0);
            check("t1_ready", in_ready, 1'b1);
        end

        // 2: single byte A5, latency, bit pattern and frame length
        base = frames_rx;
        drive(1'b1, 8'hA5);
        drive(1'b0, 8'h00);
        check("t2_tx_e0", tx, 1'b1);
        check("t2_cnt_e0", fifo_count, 3'd1);
        @(negedge clk);
        check("t2_tx_e1", tx, 1'b0);
        check("t2_busy_e1", busy, 1'b1);
        check("t2_cnt_e1", fifo_count, 3'd0);
        busy_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
        end
        check("t2_busy_len", busy_cnt, 120);
        check("t2_frames", frames_rx, base + 1);
        check("t2_bits", last_bits, {1'b1, 8'hA5, 1'b0});
        repeat (5) @(negedge clk);

        // 3: three back-to-back frames
        base = frames_rx;
        start_q.delete();
        drive(1'b1, 8'h00);
        drive(1'b1, 8'hFF);
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        peak = 0;
        for (int i = 0; i < 600 && frames_rx < base + 3; i++) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            @(negedge clk);
        end
        check("t3_frames", frames_rx, base + 3);
        check("t3_peak", peak, 2);
        check("t3_nstart", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("t3_gap01", start_q[1] - start_q[0], 120);
            check("t3_gap12", start_q[2] - start_q[1], 120);
        end
        wait_idle("t3_idle", 200);
        repeat (5) @(negedge clk);

        // 4: continuous valid with 8 bytes into a 4-deep FIFO
        base = frames_rx;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t4_ready", in_ready, i < 5);
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            if (in_ready) exp_q.push_back(8'(i + 1));
        end
        drive(1'b0, 8'h00);
        check("t4_cnt_full", fifo_count, 3'd4);
        check("t4_ready_full", in_ready, 1'b0);
        wait_frames("t4_frames", base + 5, 1000);
        wait_idle("t4_idle", 200);
        check("t4_sb_empty", exp_q.size(), 0);
        repeat (20) @(negedge clk);
        check("t4_no_extra", frames_rx, base + 5);

        // 5: reset in the middle of data bit 3 of C3 with two bytes queued
        drive(1'b1, 8'hC3);
        drive(1'b1, 8'h11);
        drive(1'b1, 8'h22);
        drive(1'b0, 8'h00);
        repeat (52) @(negedge clk);
        check("t5_cnt_pre", fifo_count, 3'd2);
        check("t5_busy_pre", busy, 1'b1);
        rst = 1'b1;
        mon_epoch++;
        exp_q.delete();
        base = frames_started;
        @(negedge clk);
        rst = 1'b0;
        check("t5_tx", tx, 1'b1);
        check("t5_cnt", fifo_count, 3'd0);
        check("t5_busy", busy, 1'b0);
        check("t5_ready", in_ready, 1'b1);
        tx_low = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) tx_low++;
        end
        check("t5_tx_low", tx_low, 0);
        check("t5_no_frames", frames_started, base);

        // 6: push collides with the STOP-exit pop while full
        base = frames_rx;
        drive(1'b1, 8'h10);
        drive(1'b1, 8'h20);
        drive(1'b1, 8'h30);
        check("t6_tx_start", tx, 1'b0);
        drive(1'b1, 8'h40);
        drive(1'b1, 8'h50);
        for (int k = 5; k <= 122; k++) begin
            @(negedge clk);
            if (k == 5)   check("t6_cnt_full", fifo_count, 3'd4);
            if (k == 121) check("t6_cnt_prepop", fifo_count, 3'd4);
            if (k == 122) check("t6_cnt_pop", fifo_count, 3'd3);
            check("t6_ready", in_ready, k == 122);
            in_valid = 1'b1;
            in_data  = 8'h3C;
            if (in_ready) exp_q.push_back(8'h3C);
        end
        drive(1'b0, 8'h00);
        check("t6_cnt_retry", fifo_count, 3'd4);
        check("t6_ready_retry", in_ready, 1'b0);
        wait_frames("t6_frames", base + 6, 1200);
        wait_idle("t6_idle", 200);
        check("t6_sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
